// File: rtl/vector_dot_product_engine.sv
// Pipelined signed fixed-point dot product: LANES multipliers time-multiplexed over
// VECTOR_LENGTH/LANES beats, then round-half-up and saturate. Optional ReLU: VECTOR_DOT_PRODUCT_RELU_EN.
module vector_dot_product_engine #(
  parameter int VECTOR_LENGTH        = 16,
  parameter int LANES                = 4,
  parameter int FIXED_POINT_LENGTH   = 16,
  parameter int FIXED_POINT_POSITION = 10
) (
  input  logic                                       clk_in,
  input  logic                                       rst_n_in,
  input  logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_1_in,
  input  logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_2_in,
  input  logic                                       in_valid_in,
  output logic                                       in_ready_out,
  output logic [FIXED_POINT_LENGTH-1:0]              product_out,
  output logic                                       saturated_out,
  output logic                                       out_valid_out,
  input  logic                                       out_ready_in,
  output logic                                       busy_out
);

  localparam int FPL    = FIXED_POINT_LENGTH;
  localparam int VW     = VECTOR_LENGTH * FPL;
  localparam int BEATS  = VECTOR_LENGTH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2 * FPL;
  localparam int ACC_W  = 2 * FPL + $clog2(VECTOR_LENGTH) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-FPL+1){1'b0}}, {(FPL-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-FPL+1){1'b1}}, {(FPL-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_NORM,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [VW-1:0]            vec_a_q, vec_a_d;
  logic [VW-1:0]            vec_b_q, vec_b_d;
  logic [FPL-1:0]           product_q, product_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [FPL-1:0]    lane_a, lane_b;
  logic signed [PROD_W-1:0] lane_p;
  logic signed [ACC_W-1:0]  beat_sum;
  logic [FPL:0]             norm_res;

  // Round half up: add half an LSB of the result, then arithmetic shift.
  function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] half;
    half = '0;
    half[FIXED_POINT_POSITION-1] = 1'b1;
    return (acc + half) >>> FIXED_POINT_POSITION;
  endfunction

  // Returns {clamped_flag, value}.
  function automatic logic [FPL:0] saturate(input logic signed [ACC_W-1:0] r);
    logic [FPL-1:0] v;
    logic           f;
    if (r > SAT_MAX) begin
      v = SAT_MAX[FPL-1:0];
      f = 1'b1;
    end else if (r < SAT_MIN) begin
      v = SAT_MIN[FPL-1:0];
      f = 1'b1;
    end else begin
      v = r[FPL-1:0];
      f = 1'b0;
    end
    return {f, v};
  endfunction

`ifdef VECTOR_DOT_PRODUCT_RELU_EN
  // Negative results (including negatively clamped ones) collapse to zero, so the
  // flag survives only for positive clamping.
  function automatic logic [FPL:0] apply_relu(input logic [FPL:0] fv);
    logic [FPL:0] res;
    res = fv;
    if (fv[FPL-1]) res = '0;
    return res;
  endfunction

  assign norm_res = apply_relu(saturate(round_acc(acc_q)));
`else
  assign norm_res = saturate(round_acc(acc_q));
`endif

  // Beat k covers elements k*LANES .. k*LANES+LANES-1.
  always_comb begin
    beat_sum = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_p   = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_a   = vec_a_q[(int'(beat_q) * LANES + l) * FPL +: FPL];
      lane_b   = vec_b_q[(int'(beat_q) * LANES + l) * FPL +: FPL];
      lane_p   = lane_a * lane_b;
      beat_sum = beat_sum + {{(ACC_W-PROD_W){lane_p[PROD_W-1]}}, lane_p};
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    vec_a_d     = vec_a_q;
    vec_b_d     = vec_b_q;
    product_d   = product_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_in) begin
          vec_a_d = vector_1_in;
          vec_b_d = vector_2_in;
          acc_d   = '0;
          beat_d  = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + beat_sum;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = S_NORM;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_NORM: begin
        product_d   = norm_res[FPL-1:0];
        sat_d       = norm_res[FPL];
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_in) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      acc_q       <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      product_q   <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      vec_a_q     <= vec_a_d;
      vec_b_q     <= vec_b_d;
      product_q   <= product_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_out  = (state_q == S_IDLE);
  assign busy_out      = (state_q != S_IDLE);
  assign product_out   = product_q;
  assign saturated_out = sat_q;
  assign out_valid_out = out_valid_q;

endmodule

// File: tb/tb_vector_dot_product_engine.sv
// Directed table-driven bench for vector_dot_product_engine (default parameters),
// plus hand-written backpressure and mid-MAC reset sequences.
module tb_vector_dot_product_engine;

  localparam int VL  = 16;
  localparam int FPL = 16;
  localparam int VW  = VL * FPL;
`ifdef VECTOR_DOT_PRODUCT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] va = '0;
  logic [VW-1:0] vb = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FPL-1:0] prod;
  logic          sat;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  int checks = 0;
  int failures = 0;

  vector_dot_product_engine #(
    .VECTOR_LENGTH(16),
    .LANES(4),
    .FIXED_POINT_LENGTH(16),
    .FIXED_POINT_POSITION(10)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .vector_1_in(va),
    .vector_2_in(vb),
    .in_valid_in(in_valid),
    .in_ready_out(in_ready),
    .product_out(prod),
    .saturated_out(sat),
    .out_valid_out(out_valid),
    .out_ready_in(out_ready),
    .busy_out(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a_fill;
    logic [15:0] b_fill;
    int          idx;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [15:0] exp_prod;
    logic        exp_sat;
  } vec_t;

  vec_t tbl[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] build(input logic [15:0] fill, input int idx, input logic [15:0] val);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*FPL +: FPL] = (i == idx) ? val : fill;
    return v;
  endfunction

  // Handshake operands in, then wait for the result and check the accept-to-valid latency.
  task automatic start_and_wait(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    va = a;
    vb = b;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check("latency", n, 32'd5);
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    check("busy_after_take", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h0400, 16'h0400, -1, 16'h0000, 16'h0000, 16'h4000, 1'b0};
    tbl[1]  = '{16'h0800, 16'h0800, -1, 16'h0000, 16'h0000, 16'h7FFF, 1'b1};
    tbl[2]  = '{16'hFC00, 16'h0400, -1, 16'h0000, 16'h0000, RELU ? 16'h0000 : 16'hC000, 1'b0};
    tbl[3]  = '{16'h0000, 16'h0000, 0, 16'h0001, 16'h0200, 16'h0001, 1'b0};
    tbl[4]  = '{16'h0000, 16'h0000, 0, 16'h0001, 16'h01FF, 16'h0000, 1'b0};
    tbl[5]  = '{16'hF800, 16'h0800, -1, 16'h0000, 16'h0000, RELU ? 16'h0000 : 16'h8000, RELU ? 1'b0 : 1'b1};
    tbl[6]  = '{16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0200, 16'h0000, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0201, RELU ? 16'h0000 : 16'hFFFF, 1'b0};
    tbl[8]  = '{16'h0400, 16'h0200, -1, 16'h0000, 16'h0000, 16'h2000, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0000, 15, 16'h0C00, 16'h0400, 16'h0C00, 1'b0};
    tbl[10] = '{16'h0000, 16'h0000, 6, 16'hFC00, 16'h0C00, RELU ? 16'h0000 : 16'hF400, 1'b0};
    tbl[11] = '{16'h0100, 16'hFE00, -1, 16'h0000, 16'h0000, RELU ? 16'h0000 : 16'hF800, 1'b0};

    // Reset state
    tick;
    tick;
    check("rst_prod", {16'd0, prod}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick;

    for (int t = 0; t < 12; t++) begin
      start_and_wait(build(tbl[t].a_fill, tbl[t].idx, tbl[t].a_val),
                     build(tbl[t].b_fill, tbl[t].idx, tbl[t].b_val));
      check($sformatf("vec%0d_prod", t), {16'd0, prod}, {16'd0, tbl[t].exp_prod});
      check($sformatf("vec%0d_sat", t), {31'd0, sat}, {31'd0, tbl[t].exp_sat});
      consume;
    end

    // Backpressure: result held, new operands refused while DONE waits.
    start_and_wait(build(16'h0400, -1, 16'h0), build(16'h0400, -1, 16'h0));
    for (int c = 0; c < 6; c++) begin
      va = build(16'h0800, -1, 16'h0);
      vb = build(16'h0800, -1, 16'h0);
      in_valid = (c % 2 == 0);
      tick;
      check("bp_prod", {16'd0, prod}, 32'h4000);
      check("bp_sat", {31'd0, sat}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume;
    tick;
    check("bp_not_captured", {31'd0, busy}, 32'd0);
    check("bp_prod_kept", {16'd0, prod}, 32'h4000);

    // Reset during beat 2 after leaving a saturated result on the outputs.
    start_and_wait(build(16'h0800, -1, 16'h0), build(16'h0800, -1, 16'h0));
    consume;
    va = build(16'h0400, -1, 16'h0);
    vb = build(16'h0400, -1, 16'h0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_prod", {16'd0, prod}, 32'd0);
    check("midrst_sat", {31'd0, sat}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    tick;
    tick;
    tick;
    tick;
    check("postrst_no_result", {31'd0, out_valid}, 32'd0);
    start_and_wait(build(16'h0400, -1, 16'h0), build(16'h0400, -1, 16'h0));
    check("postrst_prod", {16'd0, prod}, 32'h4000);
    check("postrst_sat", {31'd0, sat}, 32'd0);
    consume;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
